// File: rtl/muldiv_if.sv
// Request/result bundle between an issuing pipeline and the HI/LO multiply-divide unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One bit per cycle on operand magnitudes; signs are reapplied when the result is committed.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int unsigned W = 32;
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  RUN  = 1'b1;

    logic [0:0]     state;
    logic [0:0]     state_next;
    logic           accept_c;
    logic           last_c;

    logic [4:0]     count;
    logic           is_div;
    logic           neg_res;
    logic           neg_rem;
    logic [W-1:0]   a_q;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] acc;

    logic           signed_op;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   mag_a_in;
    logic [W-1:0]   mag_b_in;

    logic [W:0]     mul_sum;
    logic [W:0]     div_rem;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] mul_res;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    last_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes at acceptance; ops 00/10 are the signed variants
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[W-1];
        b_neg     = signed_op & bus.b[W-1];
        mag_a_in  = a_neg ? W'(-bus.a) : bus.a;
        mag_b_in  = b_neg ? W'(-bus.b) : bus.b;
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : (W+1)'(0));
        div_rem  = {acc[2*W-1:W], acc[W-1]};
        div_diff = W'(div_rem - {1'b0, mag_b});
        if (is_div) begin
            if (div_rem >= {1'b0, mag_b})
                acc_next = {div_diff, acc[W-2:0], 1'b1};
            else
                acc_next = {div_rem[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[W-1:1]};
        end
    end

    // Signed fix-up of the final iteration's value
    always_comb begin
        mul_res = neg_res ? (2*W)'(-acc_next) : acc_next;
        if (!is_div) begin
            res_hi = mul_res[2*W-1:W];
            res_lo = mul_res[W-1:0];
        end else if (mag_b == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = neg_rem ? W'(-acc_next[2*W-1:W]) : acc_next[2*W-1:W];
            res_lo = neg_res ? W'(-acc_next[W-1:0])   : acc_next[W-1:0];
        end
    end

    // Datapath, HI/LO and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            a_q      <= '0;
            mag_b    <= '0;
            acc      <= '0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.busy <= (state_next == RUN);
            if (accept_c) begin
                count   <= '0;
                is_div  <= bus.op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                a_q     <= bus.a;
                mag_b   <= mag_b_in;
                acc     <= {{W{1'b0}}, mag_a_in};
            end else if (state == RUN) begin
                acc   <= acc_next;
                count <= count + 5'd1;
                if (last_c) begin
                    bus.hi   <= res_hi;
                    bus.lo   <= res_lo;
                    bus.done <= 1'b1;
                end
            end else begin
                if (bus.hi_we) bus.hi <= bus.wdata;
                if (bus.lo_we) bus.lo <= bus.wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against a plain-arithmetic HI/LO reference.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     q;
        int     r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Present a start for one edge (optionally with HI/LO writes that must be ignored)
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic we);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        bus.hi_we = we;
        bus.lo_we = we;
        bus.wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Follow a running op to completion, optionally poking start / hi_we mid-run
    task automatic finish_op(input logic [63:0] exp, input int inj_start, input int inj_we);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            check("hold_hi", {32'h0, bus.hi}, {32'h0, hi_m});
            check("hold_lo", {32'h0, bus.lo}, {32'h0, lo_m});
            check("done_while_busy", {63'h0, bus.done}, 64'h0);
            if (n == inj_start) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.a     = 32'd100;
                bus.b     = 32'd7;
            end
            if (n == inj_we) begin
                bus.hi_we = 1'b1;
                bus.wdata = 32'hAAAA_5555;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
        end
        check("busy_cycles", 64'(n), 64'd32);
        check("done_pulse", {63'h0, bus.done}, 64'h1);
        check("result", {bus.hi, bus.lo}, exp);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        @(posedge clk); #1;
        check("done_clear", {63'h0, bus.done}, 64'h0);
        check("idle_after", {63'h0, bus.busy}, 64'h0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, 1'b0);
        finish_op(model(o, x, y), -1, -1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;

        // Reset with start and writes asserted: all must be ignored
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hFFFF_0000;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_done", {63'h0, bus.done}, 64'h0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        reset = 1'b0;
        hi_m = 32'h0;
        lo_m = 32'h0;
        @(posedge clk); #1;
        check("post_rst_busy", {63'h0, bus.busy}, 64'h0);

        // Directed results
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_neg_const", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_const", {hi_m, lo_m}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_m1_const", {hi_m, lo_m}, 64'h0000_0000_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg_const", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002);
        check("divu_const", {hi_m, lo_m}, 64'h0000_0001_0000_0003);
        run_op(2'b11, 32'h1234_5678, 32'h0);
        check("divu_zero_const", {hi_m, lo_m}, 64'h1234_5678_FFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi_m, lo_m}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'h8765_4321, 32'h0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);

        // Random operations, with occasional zero divisors and small operands
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 40));
            if ($urandom_range(0, 5) == 0) rb = -rb;
            run_op(ro, ra, rb);
        end

        // Start with HI/LO writes on the acceptance edge; writes must not land
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        finish_op(64'd42, -1, -1);

        // Start and hi_we while busy are ignored
        issue(2'b01, 32'd3, 32'd5, 1'b0);
        finish_op(64'h0000_0000_0000_000F, 10, 20);
        check("busy_ignore_const", {hi_m, lo_m}, 64'h0000_0000_0000_000F);

        // Idle HI/LO writes, together and separately
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_DEAD_BEEF);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0123_4567;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi_only", {bus.hi, bus.lo}, 64'h0123_4567_DEAD_BEEF);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h89AB_CDEF;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("mtlo_only", {bus.hi, bus.lo}, 64'h0123_4567_89AB_CDEF);
        hi_m = 32'h0123_4567;
        lo_m = 32'h89AB_CDEF;

        // Reset 15 cycles into a MULT aborts it
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("mid_run_busy", {63'h0, bus.busy}, 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'h0, bus.busy}, 64'h0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        hi_m = 32'h0;
        lo_m = 32'h0;
        for (int i = 0; i < 40; i++) begin
            check("abort_no_done", {62'h0, bus.done, bus.busy}, 64'h0);
            @(posedge clk); #1;
        end
        run_op(2'b01, 32'd2, 32'd2);
        check("post_abort_const", {hi_m, lo_m}, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin the operation selected by op, using operands a and b.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend.
REQ-007 b  input  32  multiplier or divisor.
REQ-008 hi_we  input  1  write wdata into HI (MTHI).
REQ-009 lo_we  input  1  write wdata into LO (MTLO).
REQ-010 wdata  input  32  data for HI/LO writes.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when the result is committed.
REQ-013 hi  output  32  HI register, read by MFHI.
REQ-014 lo  output  32  LO register, read by MFLO.

Function
REQ-015 The block SHALL use a two-state FSM (IDLE, RUN) and a 5-bit iteration counter; busy SHALL equal (state==RUN).
REQ-016 start SHALL be accepted only at a clock edge where state==IDLE and reset==0; at that edge E0 the block SHALL latch op, a and b, clear the counter, and enter RUN.
REQ-017 start while busy SHALL be ignored, with no effect on state, operands or result.
REQ-018 An operation SHALL take exactly 32 iteration edges (E1..E32), one per iteration; iteration SHALL be shift-add for multiply and restoring for divide, on magnitudes.
REQ-019 At E32 the block SHALL write hi/lo, return to IDLE, and assert done for exactly the cycle following E32; busy SHALL be high for exactly 32 cycles.
REQ-020 hi/lo SHALL hold their previous values throughout RUN; partial results SHALL live only in internal registers.
REQ-021 MULT: {hi,lo} SHALL equal the 64-bit two's-complement product of signed a and signed b; MULTU: the unsigned 64-bit product.
REQ-022 DIVU: lo SHALL equal the unsigned quotient and hi the unsigned remainder.
REQ-023 DIV: lo SHALL equal the quotient truncated toward zero, and hi the remainder carrying the sign of the dividend (or zero).
REQ-024 For divide by zero (b==0, DIV or DIVU), lo SHALL be FFFFFFFF and hi SHALL be a; no exception is raised.
REQ-025 DIV 80000000 / FFFFFFFF SHALL give lo=80000000 and hi=00000000.
REQ-026 In IDLE, hi_we SHALL load wdata into hi and lo_we SHALL load wdata into lo at the clock edge; both may be asserted in the same cycle.
REQ-027 hi_we/lo_we SHALL be ignored while busy, and also at an edge where start is accepted.
REQ-028 done SHALL never be asserted together with busy.

Reset
REQ-029 While reset==1 at a clock edge: state SHALL go to IDLE, counter and internal accumulators SHALL clear, and hi, lo, busy and done SHALL all be 0.
REQ-030 Reset during RUN SHALL abort the operation; no done pulse SHALL follow, and hi/lo SHALL be 0.
REQ-031 start, hi_we and lo_we asserted in a reset cycle SHALL be ignored.

Verification
REQ-032 MULT a=FFFFFFFE, b=00000003 -> busy for 32 cycles, then done one cycle; hi=FFFFFFFF, lo=FFFFFFFA.
REQ-033 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; MULT of the same operands -> hi=00000000, lo=00000001.
REQ-034 DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=00000007, b=00000002 -> lo=00000003, hi=00000001.
REQ-035 DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-036 Under these conditions -> results match the first operation only and hi=AAAA5555 is not observed:
  - MULTU 3x5 started;
  - second start (op=DIVU) applied at cycle 10;
  - hi_we with wdata=AAAA5555 applied at cycle 20.
  Expected: hi=0, lo=0000000F.
  Then in IDLE: hi_we + lo_we with wdata=DEADBEEF -> hi=lo=DEADBEEF on the next cycle.
REQ-037 Reset asserted 15 cycles into a MULT -> busy=0, hi=lo=0, and no done pulse; a new MULTU 2x2 -> lo=00000004 after 32 cycles.
